// File: rtl/poly8_pkg.sv
// Shared types and helpers for the poly8 Horner evaluator.
// POLY8_SAT_EN selects saturating (defined) or wrapping (undefined) fit16.
package poly8_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 32;
    localparam int NCOEF  = 9;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    // Narrow the 33-bit Horner step result back to the 16-bit accumulator width.
    function automatic logic [DATA_W-1:0] fit16(input logic [DATA_W+PROD_W-DATA_W:0] s);
`ifdef POLY8_SAT_EN
        if (s[32] && !(&s[31:15]))
            return 16'h8000;
        else if (!s[32] && (|s[31:15]))
            return 16'h7fff;
        else
            return s[15:0];
`else
        logic unused_hi;
        unused_hi = ^s[32:16];
        return s[15:0];
`endif
    endfunction

endpackage

// File: rtl/poly8_horner_ctrl_mul.sv
// Combinational 16x16 signed multiplier shared by the Horner sequencer.
module poly8_mul_mul_16s_16s_32_1_1 #(
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 16,
    parameter int dout_WIDTH = 32
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    assign dout = dout_WIDTH'($signed(din0) * $signed(din1));

endmodule

// File: rtl/poly8_horner_ctrl.sv
// Horner-rule sequencer for an 8th-order fixed-point polynomial over one shared multiplier.
// Optional macro POLY8_SAT_EN enables saturation and the sticky ovf flag.
module poly8_horner_ctrl
    import poly8_pkg::*;
#(
    parameter int FRAC = 8
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [15:0] x_in,
    input  logic        coef_we,
    input  logic [3:0]  coef_addr,
    input  logic [15:0] coef_din,
    output logic [15:0] y_out,
    output logic        ovf
);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] coef [NCOEF];
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] x_r;
    logic [CNT_W-1:0]  cnt;

    // A write landing in the start cycle must not leak into the evaluation,
    // so the overwritten entry's old value is kept aside for the run.
    logic              shadow_valid;
    logic [CNT_W-1:0]  shadow_addr;
    logic [DATA_W-1:0] shadow_val;

    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_sh;
    logic [DATA_W-1:0] coef_sel;
    logic [PROD_W:0]   s;
    logic [DATA_W-1:0] s_fit;
    logic              coef_ok;

    poly8_mul_mul_16s_16s_32_1_1 #(
        .din0_WIDTH(16),
        .din1_WIDTH(16),
        .dout_WIDTH(32)
    ) u_mul (
        .din0(acc),
        .din1(x_r),
        .dout(prod)
    );

    assign coef_ok  = coef_we && ap_idle && (coef_addr <= 4'd8);
    assign coef_sel = (shadow_valid && (shadow_addr == cnt)) ? shadow_val : coef[cnt];
    assign prod_sh  = $signed(prod) >>> FRAC;
    assign s        = {prod_sh[PROD_W-1], prod_sh} + {{(PROD_W+1-DATA_W){coef_sel[DATA_W-1]}}, coef_sel};
    assign s_fit    = fit16(s);

    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        ap_idle    = 1'b0;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start)
                    state_next = S_ITER;
            end
            S_ITER: begin
                if (cnt == '0)
                    state_next = S_DONE;
            end
            S_DONE: begin
                ap_done    = 1'b1;
                ap_ready   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NCOEF; i++)
                coef[i] <= '0;
        end else if (coef_ok) begin
            coef[coef_addr] <= coef_din;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc          <= '0;
            x_r          <= '0;
            cnt          <= '0;
            y_out        <= '0;
            shadow_valid <= 1'b0;
            shadow_addr  <= '0;
            shadow_val   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        x_r          <= x_in;
                        acc          <= coef[8];
                        cnt          <= CNT_W'(7);
                        shadow_valid <= coef_ok;
                        shadow_addr  <= coef_addr;
                        if (coef_ok)
                            shadow_val <= coef[coef_addr];
                    end
                end
                S_ITER: begin
                    acc <= s_fit;
                    if (cnt == '0)
                        y_out <= s_fit;
                    else
                        cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef POLY8_SAT_EN
    logic sat;
    assign sat = !((&s[32:15]) || !(|s[32:15]));

    always_ff @(posedge ap_clk) begin
        if (ap_rst)
            ovf <= 1'b0;
        else if (state == S_IDLE && ap_start)
            ovf <= 1'b0;
        else if (state == S_ITER && sat)
            ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_poly8_horner_ctrl.sv
// Self-checking bench for poly8_horner_ctrl against a plain-arithmetic Horner model.
module tb_poly8_horner_ctrl;

    logic        ap_clk;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [15:0] x_in;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [15:0] coef_din;
    logic [15:0] y_out;
    logic        ovf;

    int compared   = 0;
    int mismatched = 0;

    // Reference coefficient bank as the bench believes the DUT holds it.
    logic [15:0] mc [9];

    poly8_horner_ctrl #(.FRAC(8)) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .x_in     (x_in),
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_din (coef_din),
        .y_out    (y_out),
        .ovf      (ovf)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Horner evaluation with plain integer arithmetic; floor shift by 8 bits.
    function automatic logic [15:0] modelEval(input logic [15:0] x, output bit sat);
        longint acc;
        longint t;
        sat = 1'b0;
        acc = longint'($signed(mc[8]));
        for (int i = 7; i >= 0; i--) begin
            t = ((acc * longint'($signed(x))) >>> 8) + longint'($signed(mc[i]));
`ifdef POLY8_SAT_EN
            if (t > 32767) begin
                t = 32767;
                sat = 1'b1;
            end else if (t < -32768) begin
                t = -32768;
                sat = 1'b1;
            end
`else
            t = longint'($signed(16'(t)));
`endif
            acc = t;
        end
        return 16'(acc);
    endfunction

    task automatic writeCoef(input logic [3:0] addr, input logic [15:0] val);
        @(negedge ap_clk);
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_din  = val;
        if (addr <= 4'd8)
            mc[addr] = val;
        @(negedge ap_clk);
        coef_we = 1'b0;
    endtask

    task automatic setAll(input logic [15:0] val);
        for (int i = 0; i < 9; i++)
            writeCoef(4'(i), val);
    endtask

    // One evaluation; optionally a coefficient write in the start cycle.
    task automatic applyStimulus(input string tag, input logic [15:0] x, input bit doWr,
                                 input logic [3:0] wa, input logic [15:0] wd);
        logic [15:0] expY;
        bit          expSat;
        int          n;
        expY = modelEval(x, expSat);
        @(negedge ap_clk);
        ap_start  = 1'b1;
        x_in      = x;
        coef_we   = doWr;
        coef_addr = wa;
        coef_din  = wd;
        if (doWr && wa <= 4'd8)
            mc[wa] = wd;
        @(negedge ap_clk);
        ap_start = 1'b0;
        coef_we  = 1'b0;
        x_in     = 16'($urandom);
        coef_din = 16'($urandom);
        n = 1;
        while (!ap_done && n < 20) begin
            @(negedge ap_clk);
            n++;
        end
        checkOutput({tag, ".latency"}, 32'(n), 32'd9);
        checkOutput({tag, ".y"}, 32'(y_out), 32'(expY));
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'(expSat));
        checkOutput({tag, ".ready"}, 32'(ap_ready), 32'd1);
        @(negedge ap_clk);
        checkOutput({tag, ".idle_after"}, 32'(ap_idle), 32'd1);
        checkOutput({tag, ".done_low"}, 32'(ap_done), 32'd0);
    endtask

    function automatic logic [15:0] randVal();
        if ($urandom_range(0, 1) == 0)
            return 16'($urandom_range(0, 1023)) - 16'd512;
        return 16'($urandom);
    endfunction

    initial begin
        int          doneCount;
        int          n;
        logic [15:0] expY;
        bit          expSat;

        ap_rst    = 1'b1;
        ap_start  = 1'b0;
        x_in      = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_din  = '0;
        for (int i = 0; i < 9; i++)
            mc[i] = '0;
        repeat (3) @(negedge ap_clk);
        checkOutput("reset.idle", 32'(ap_idle), 32'd1);
        checkOutput("reset.done", 32'(ap_done), 32'd0);
        checkOutput("reset.ready", 32'(ap_ready), 32'd0);
        checkOutput("reset.y", 32'(y_out), 32'd0);
        checkOutput("reset.ovf", 32'(ovf), 32'd0);
        ap_rst = 1'b0;

        writeCoef(4'd0, 16'd5);
        applyStimulus("t1", 16'd256, 1'b0, 4'd0, 16'd0);
        checkOutput("t1.const", 32'(y_out), 32'd5);

        writeCoef(4'd0, 16'd0);
        writeCoef(4'd1, 16'd256);
        applyStimulus("t2a", 16'd512, 1'b0, 4'd0, 16'd0);
        checkOutput("t2a.const", 32'(y_out), 32'd512);
        writeCoef(4'd2, 16'd256);
        applyStimulus("t2b", 16'd512, 1'b0, 4'd0, 16'd0);
        checkOutput("t2b.const", 32'(y_out), 32'd1536);

        setAll(16'd32767);
        applyStimulus("t3", 16'd32767, 1'b0, 4'd0, 16'd0);
`ifdef POLY8_SAT_EN
        checkOutput("t3.sat_y", 32'(y_out), 32'd32767);
        checkOutput("t3.sat_ovf", 32'(ovf), 32'd1);
`else
        checkOutput("t3.wrap_ovf", 32'(ovf), 32'd0);
`endif

        // Busy-time start requests and writes must be ignored.
        setAll(16'd100);
        writeCoef(4'd0, 16'd77);
        expY = modelEval(16'd300, expSat);
        @(negedge ap_clk);
        ap_start = 1'b1;
        x_in     = 16'd300;
        @(negedge ap_clk);
        ap_start  = 1'b0;
        doneCount = 0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 3) begin
                ap_start  = 1'b1;
                coef_we   = 1'b1;
                coef_addr = 4'd0;
                coef_din  = 16'h1234;
            end
            if (c == 10) begin
                ap_start = 1'b0;
                coef_we  = 1'b0;
            end
            if (ap_done) begin
                doneCount++;
                checkOutput("t4.done_cycle", 32'(c), 32'd9);
                checkOutput("t4.y", 32'(y_out), 32'(expY));
            end
            @(negedge ap_clk);
        end
        checkOutput("t4.done_count", 32'(doneCount), 32'd1);
        applyStimulus("t4.c0_kept", 16'd300, 1'b0, 4'd0, 16'd0);

        // Reset in the middle of an evaluation.
        @(negedge ap_clk);
        ap_start = 1'b1;
        x_in     = 16'd1000;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        for (int i = 0; i < 9; i++)
            mc[i] = '0;
        checkOutput("t5.idle", 32'(ap_idle), 32'd1);
        checkOutput("t5.y", 32'(y_out), 32'd0);
        doneCount = 0;
        for (int c = 0; c < 10; c++) begin
            if (ap_done)
                doneCount++;
            @(negedge ap_clk);
        end
        checkOutput("t5.no_done", 32'(doneCount), 32'd0);
        applyStimulus("t5.after", 16'd100, 1'b0, 4'd0, 16'd0);
        checkOutput("t5.zero", 32'(y_out), 32'd0);

        // Out-of-range addresses are ignored.
        setAll(16'd3);
        for (int a = 9; a < 16; a++)
            writeCoef(4'(a), 16'h7abc);
        applyStimulus("t6.badaddr", 16'd128, 1'b0, 4'd0, 16'd0);

        for (int r = 0; r < 1000; r++) begin
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++)
                writeCoef(4'($urandom_range(0, 15)), randVal());
            applyStimulus("t6.rand", randVal(), ($urandom_range(0, 3) == 0),
                          4'($urandom_range(0, 15)), randVal());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
